// File: rtl/ternary_adder_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ternary_adder_tree_pkg
// Description : Shared constants and width helpers for the ternary adder tree.
//               The sat_trunc helper serves the TERNARY_ADDER_SAT_EN build.
// Revision    : 1.0 - initial release
// ============================================================================
package ternary_adder_tree_pkg;

   localparam int DEFAULT_WIDTH = 16;
   // Widest intermediate sum that sat_trunc can clamp
   localparam int MAX_W         = 64;

   function automatic int s1_width(input int width);
      return width + 2;
   endfunction

   function automatic int s2_width(input int width);
      return width + 3;
   endfunction

   // Clamp sum to all-ones in the low 'width' bits if any higher bit is set
   function automatic logic [MAX_W-1:0] sat_trunc(input logic [MAX_W-1:0] sum,
                                                  input int               width);
      logic             ovf;
      logic [MAX_W-1:0] res;
      ovf = 1'b0;
      res = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i >= width) ovf = ovf | sum[i];
         else            res[i] = sum[i];
      end
      if (ovf) begin
         for (int i = 0; i < MAX_W; i++) begin
            if (i < width) res[i] = 1'b1;
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ternary_add3.sv
`default_nettype none
// ============================================================================
// Module      : ternary_add3
// Description : Combinational 3-input unsigned adder: carry-save compression
//               followed by one carry-propagate add.
// Revision    : 1.0 - initial release
// ============================================================================
module ternary_add3 #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 18
) (
   input  logic [IN_W-1:0]  i_a,
   input  logic [IN_W-1:0]  i_b,
   input  logic [IN_W-1:0]  i_c,
   output logic [OUT_W-1:0] o_sum
);

   logic [IN_W-1:0] w_psum;
   logic [IN_W-1:0] w_gen;

   always_comb begin
      w_psum = i_a ^ i_b ^ i_c;
      // Majority bit is the carry into the next column
      w_gen  = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
      o_sum  = OUT_W'(w_psum) + (OUT_W'(w_gen) << 1);
   end

endmodule
`default_nettype wire

// File: rtl/ternary_adder_tree.sv
`default_nettype none
// ============================================================================
// Module      : ternary_adder_tree
// Description : Two-stage pipelined 5-operand unsigned adder, OUT = A+B+C+D+E.
//               Define TERNARY_ADDER_SAT_EN to saturate instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module ternary_adder_tree
   import ternary_adder_tree_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] E,
   output logic [WIDTH-1:0] OUT
);

   localparam int S1_W = s1_width(WIDTH);
   localparam int S2_W = s2_width(WIDTH);

   logic [S1_W-1:0]  s1_d,  s1_q;
   logic [WIDTH-1:0] d1_d,  d1_q;
   logic [WIDTH-1:0] e1_d,  e1_q;
   logic [WIDTH-1:0] out_d, out_q;

   logic [S1_W-1:0]  w_s1_sum;
   logic [S2_W-1:0]  w_s2_sum;

   ternary_add3 #(
      .IN_W  (WIDTH),
      .OUT_W (S1_W)
   ) u_stage1 (
      .i_a   (A),
      .i_b   (B),
      .i_c   (C),
      .o_sum (w_s1_sum)
   );

   ternary_add3 #(
      .IN_W  (S1_W),
      .OUT_W (S2_W)
   ) u_stage2 (
      .i_a   (s1_q),
      .i_b   (S1_W'(d1_q)),
      .i_c   (S1_W'(e1_q)),
      .o_sum (w_s2_sum)
   );

   always_comb begin
      s1_d = w_s1_sum;
      d1_d = D;
      e1_d = E;
`ifdef TERNARY_ADDER_SAT_EN
      out_d = WIDTH'(sat_trunc(MAX_W'(w_s2_sum), WIDTH));
`else
      out_d = WIDTH'(w_s2_sum);
`endif
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_q  <= '0;
         d1_q  <= '0;
         e1_q  <= '0;
         out_q <= '0;
      end else begin
         s1_q  <= s1_d;
         d1_q  <= d1_d;
         e1_q  <= e1_d;
         out_q <= out_d;
      end
   end

   assign OUT = out_q;

endmodule
`default_nettype wire

// File: tb/tb_ternary_adder_tree.sv
`default_nettype none
// Self-checking bench for ternary_adder_tree (WIDTH=16) against a plain
// arithmetic reference of the five-operand sum.
module tb_ternary_adder_tree;

   localparam int WIDTH = 16;

   logic             CLK;
   logic             RST_N;
   logic [WIDTH-1:0] A, B, C, D, E;
   logic [WIDTH-1:0] OUT;

   int total = 0;
   int bad   = 0;

   ternary_adder_tree #(.WIDTH(WIDTH)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .A     (A),
      .B     (B),
      .C     (C),
      .D     (D),
      .E     (E),
      .OUT   (OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [WIDTH-1:0] model(input int a, input int b, input int c,
                                              input int d, input int e);
      int s;
      s = a + b + c + d + e;
`ifdef TERNARY_ADDER_SAT_EN
      if (s > 65535) return 16'hFFFF;
`endif
      return 16'(s % 65536);
   endfunction

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                        input logic [WIDTH-1:0] e);
      A = a; B = b; C = c; D = d; E = e;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         cyc();
         total++;
         if (OUT !== 16'h0) begin
            bad++;
            $display("FAIL reset_hold cycle %0d: OUT=%h expected=0000", i, OUT);
         end
      end
      drive(1, 1, 1, 1, 1);
      RST_N = 1'b1;
      cyc();
      total++;
      if (OUT !== 16'h0) begin
         bad++;
         $display("FAIL reset_release_edge1: OUT=%h expected=0000", OUT);
      end
      cyc();
      total++;
      if (OUT !== 16'd5) begin
         bad++;
         $display("FAIL reset_release_edge2: OUT=%h expected=0005", OUT);
      end
   endtask

   task automatic test_small_sum();
      drive(1, 2, 3, 4, 5);
      cyc();
      cyc();
      total++;
      if (OUT !== 16'd15) begin
         bad++;
         $display("FAIL small_sum: OUT=%h expected=000f", OUT);
      end
   endtask

   task automatic test_overflow();
      logic [WIDTH-1:0] exp;
      drive(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      cyc();
      cyc();
`ifdef TERNARY_ADDER_SAT_EN
      exp = 16'hFFFF;
`else
      exp = 16'hFFFB;
`endif
      total++;
      if (OUT !== exp) begin
         bad++;
         $display("FAIL overflow_all_ones: OUT=%h expected=%h", OUT, exp);
      end
      drive(16'h8000, 16'h8000, 0, 0, 0);
      cyc();
      cyc();
`ifdef TERNARY_ADDER_SAT_EN
      exp = 16'hFFFF;
`else
      exp = 16'h0000;
`endif
      total++;
      if (OUT !== exp) begin
         bad++;
         $display("FAIL overflow_half_pair: OUT=%h expected=%h", OUT, exp);
      end
   endtask

   task automatic test_stream();
      logic [WIDTH-1:0] q[$];
      logic [WIDTH-1:0] exp;
      int a, b, c, d, e;
      for (int i = 0; i <= 1000; i++) begin
         if (i < 1000) begin
            a = int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 65535));
            c = int'($urandom_range(0, 65535));
            d = int'($urandom_range(0, 65535));
            e = int'($urandom_range(0, 65535));
            // Bias some vectors toward the top of the range
            if (i % 7 == 0) begin a = 65535; b = 65535 - (i % 3); end
            drive(16'(a), 16'(b), 16'(c), 16'(d), 16'(e));
            q.push_back(model(a, b, c, d, e));
         end
         cyc();
         if (i >= 1) begin
            exp = q.pop_front();
            total++;
            if (OUT !== exp) begin
               bad++;
               $display("FAIL stream vec %0d: OUT=%h expected=%h", i - 1, OUT, exp);
            end
         end
      end
   endtask

   task automatic test_stability();
      drive(16'h1234, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
      for (int i = 1; i <= 10; i++) begin
         cyc();
         if (i >= 2) begin
            total++;
            if (OUT !== 16'h1238) begin
               bad++;
               $display("FAIL stability cycle %0d: OUT=%h expected=1238", i, OUT);
            end
         end
      end
   endtask

   task automatic test_midstream_reset();
      int a, b, c, d, e;
      logic [WIDTH-1:0] exp;
      for (int i = 0; i < 3; i++) begin
         drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         cyc();
      end
      #2;
      RST_N = 1'b0;
      #1;
      total++;
      if (OUT !== 16'h0) begin
         bad++;
         $display("FAIL midreset_async: OUT=%h expected=0000", OUT);
      end
      for (int i = 0; i < 2; i++) begin
         cyc();
         total++;
         if (OUT !== 16'h0) begin
            bad++;
            $display("FAIL midreset_hold %0d: OUT=%h expected=0000", i, OUT);
         end
      end
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      c = int'($urandom_range(0, 65535));
      d = int'($urandom_range(0, 65535));
      e = int'($urandom_range(0, 65535));
      drive(16'(a), 16'(b), 16'(c), 16'(d), 16'(e));
      exp = model(a, b, c, d, e);
      RST_N = 1'b1;
      cyc();
      total++;
      if (OUT !== 16'h0) begin
         bad++;
         $display("FAIL midreset_release_edge1: OUT=%h expected=0000", OUT);
      end
      drive(16'd7, 16'd8, 16'd9, 16'd10, 16'd11);
      cyc();
      total++;
      if (OUT !== exp) begin
         bad++;
         $display("FAIL midreset_release_edge2: OUT=%h expected=%h", OUT, exp);
      end
      cyc();
      total++;
      if (OUT !== 16'd45) begin
         bad++;
         $display("FAIL midreset_resume: OUT=%h expected=002d", OUT);
      end
   endtask

   initial begin
      RST_N = 1'b0;
      drive(0, 0, 0, 0, 0);
      #1;
      total++;
      if (OUT !== 16'h0) begin
         bad++;
         $display("FAIL reset_initial: OUT=%h expected=0000", OUT);
      end
      test_reset();
      test_small_sum();
      drive(0, 0, 0, 0, 0);
      cyc();
      cyc();
      total++;
      if (OUT !== 16'h0) begin
         bad++;
         $display("FAIL all_zero: OUT=%h expected=0000", OUT);
      end
      test_overflow();
      test_stream();
      test_stability();
      test_midstream_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
